// File: rtl/hangman_pkg.sv
// Shared letter encoding and FSM state type for the hangman game-rule engine.
package hangman_pkg;
  localparam int                 LETTER_W    = 6;
  localparam logic [LETTER_W-1:0] LETTER_A   = 6'h0A;
  localparam logic [LETTER_W-1:0] LETTER_Z   = 6'h23;
  localparam int                 NUM_LETTERS = 26;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    CHECK = 3'd2,
    WON   = 3'd3,
    LOST  = 3'd4
  } state_t;
endpackage

// File: rtl/letter_match.sv
// Compares one guessed letter code against the four secret letters at once.
module letter_match
  import hangman_pkg::*;
(
  input  logic [LETTER_W-1:0] i_guess,
  input  logic [LETTER_W-1:0] i_letter1,
  input  logic [LETTER_W-1:0] i_letter2,
  input  logic [LETTER_W-1:0] i_letter3,
  input  logic [LETTER_W-1:0] i_letter4,
  output logic [3:0]          o_match,
  output logic                o_in_range
);
  always_comb begin
    o_match[0] = (i_guess == i_letter1);
    o_match[1] = (i_guess == i_letter2);
    o_match[2] = (i_guess == i_letter3);
    o_match[3] = (i_guess == i_letter4);
    o_in_range = (i_guess >= LETTER_A) && (i_guess <= LETTER_Z);
  end
endmodule

// File: rtl/hangman_judge.sv
// Hangman rule engine: latches a secret word, scores one guess per handshake,
// tracks reveals/misses and reports win or loss.
module hangman_judge
  import hangman_pkg::*;
#(
  parameter int                  MAX_MISSES = 6,
  parameter logic [LETTER_W-1:0] BLANK      = 6'h3F
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                new_game,
  input  logic [LETTER_W-1:0] letter1,
  input  logic [LETTER_W-1:0] letter2,
  input  logic [LETTER_W-1:0] letter3,
  input  logic [LETTER_W-1:0] letter4,
  input  logic                guess_valid,
  input  logic [LETTER_W-1:0] guess,
  output logic                guess_ready,
  output logic [3:0]          revealed,
  output logic [LETTER_W-1:0] shown1,
  output logic [LETTER_W-1:0] shown2,
  output logic [LETTER_W-1:0] shown3,
  output logic [LETTER_W-1:0] shown4,
  output logic [2:0]          misses,
  output logic                result_valid,
  output logic                hit,
  output logic                dup,
  output logic                bad,
  output logic                won,
  output logic                lost
);
  localparam logic [2:0] MISS_MAX = 3'(MAX_MISSES);

  state_t                    r_state;
  state_t                    w_state_next;
  logic [LETTER_W-1:0]       r_word [4];
  logic [LETTER_W-1:0]       r_guess;
  logic [NUM_LETTERS-1:0]    r_used;
  logic [3:0]                r_revealed;
  logic [2:0]                r_misses;
  logic                      r_result_valid;
  logic                      r_hit;
  logic                      r_dup;
  logic                      r_bad;

  logic [3:0]                w_match;
  logic                      w_in_range;
  logic [4:0]                w_index;
  logic [NUM_LETTERS-1:0]    w_used_bit;
  logic                      w_is_dup;
  logic                      w_is_hit;
  logic                      w_is_miss;
  logic [3:0]                w_revealed_next;
  logic [2:0]                w_misses_next;
  logic                      w_accept;

  letter_match u_letter_match (
    .i_guess    (r_guess),
    .i_letter1  (r_word[0]),
    .i_letter2  (r_word[1]),
    .i_letter3  (r_word[2]),
    .i_letter4  (r_word[3]),
    .o_match    (w_match),
    .o_in_range (w_in_range)
  );

  // Handshake: a guess transfers on a rising edge where guess_valid && guess_ready;
  // guess_ready is high only in PLAY, and new_game on the same edge drops the guess.
  assign w_accept = guess_valid && guess_ready && !new_game;

  always_comb begin
    w_index         = 5'(r_guess - LETTER_A);
    w_used_bit      = NUM_LETTERS'(1) << w_index;
    w_is_dup        = w_in_range && |(r_used & w_used_bit);
    w_is_hit        = w_in_range && !w_is_dup && |w_match;
    w_is_miss       = w_in_range && !w_is_dup && !(|w_match);
    w_revealed_next = w_is_hit ? (r_revealed | w_match) : r_revealed;
    w_misses_next   = (w_is_miss && r_misses != MISS_MAX) ? r_misses + 3'd1 : r_misses;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      PLAY:  if (guess_valid) w_state_next = CHECK;
      CHECK: begin
        if (w_revealed_next == 4'b1111)    w_state_next = WON;
        else if (w_misses_next == MISS_MAX) w_state_next = LOST;
        else                                w_state_next = PLAY;
      end
      default: w_state_next = r_state;
    endcase
    if (new_game) w_state_next = PLAY;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      for (int i = 0; i < 4; i++) r_word[i] <= '0;
      r_guess        <= '0;
      r_used         <= '0;
      r_revealed     <= '0;
      r_misses       <= '0;
      r_result_valid <= 1'b0;
      r_hit          <= 1'b0;
      r_dup          <= 1'b0;
      r_bad          <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_result_valid <= 1'b0;
      r_hit          <= 1'b0;
      r_dup          <= 1'b0;
      r_bad          <= 1'b0;
      if (new_game) begin
        r_word[0]  <= letter1;
        r_word[1]  <= letter2;
        r_word[2]  <= letter3;
        r_word[3]  <= letter4;
        r_used     <= '0;
        r_revealed <= '0;
        r_misses   <= '0;
      end else begin
        if (w_accept) r_guess <= guess;
        if (r_state == CHECK) begin
          r_revealed     <= w_revealed_next;
          r_misses       <= w_misses_next;
          if (w_is_hit || w_is_miss) r_used <= r_used | w_used_bit;
          r_result_valid <= 1'b1;
          r_hit          <= w_is_hit;
          r_dup          <= w_is_dup;
          r_bad          <= !w_in_range;
        end
      end
    end
  end

  assign guess_ready  = (r_state == PLAY);
  assign won          = (r_state == WON);
  assign lost         = (r_state == LOST);
  assign revealed     = r_revealed;
  assign misses       = r_misses;
  assign result_valid = r_result_valid;
  assign hit          = r_hit;
  assign dup          = r_dup;
  assign bad          = r_bad;
  assign shown1       = r_revealed[0] ? r_word[0] : BLANK;
  assign shown2       = r_revealed[1] ? r_word[1] : BLANK;
  assign shown3       = r_revealed[2] ? r_word[2] : BLANK;
  assign shown4       = r_revealed[3] ? r_word[3] : BLANK;
endmodule

// File: tb/tb_hangman_judge.sv
// Bench for hangman_judge: directed games plus random games against a set-based model.
module tb_hangman_judge;
  localparam int MAXM = 6;
  localparam int W    = 12;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       new_game = 1'b0;
  logic [5:0] letter1 = '0, letter2 = '0, letter3 = '0, letter4 = '0;
  logic       guess_valid = 1'b0;
  logic [5:0] guess = '0;
  logic       guess_ready;
  logic [3:0] revealed;
  logic [5:0] shown1, shown2, shown3, shown4;
  logic [2:0] misses;
  logic       result_valid, hit, dup, bad, won, lost;

  hangman_judge #(.MAX_MISSES(MAXM), .BLANK(6'h3F)) dut (
    .clock(clock), .reset(reset), .new_game(new_game),
    .letter1(letter1), .letter2(letter2), .letter3(letter3), .letter4(letter4),
    .guess_valid(guess_valid), .guess(guess), .guess_ready(guess_ready),
    .revealed(revealed), .shown1(shown1), .shown2(shown2), .shown3(shown3), .shown4(shown4),
    .misses(misses), .result_valid(result_valid), .hit(hit), .dup(dup), .bad(bad),
    .won(won), .lost(lost)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "time limit");
  end

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: the game is the secret word plus the set of letters tried.
  logic [5:0] m_word[4];
  logic [5:0] m_guessed[$];
  int         m_misses;

  function automatic bit was_guessed(input logic [5:0] g);
    foreach (m_guessed[i]) if (m_guessed[i] == g) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_revealed();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = was_guessed(m_word[i]);
    return r;
  endfunction

  function automatic logic [23:0] model_shown();
    logic [3:0] r;
    logic [5:0] s[4];
    r = model_revealed();
    for (int i = 0; i < 4; i++) s[i] = r[i] ? m_word[i] : 6'h3F;
    return {s[0], s[1], s[2], s[3]};
  endfunction

  function automatic bit model_won();
    return model_revealed() == 4'hF;
  endfunction

  function automatic bit model_over();
    return model_won() || (m_misses == MAXM);
  endfunction

  function automatic logic [W-1:0] model_status(input bit h, input bit d, input bit b);
    bit w;
    w = model_won();
    return {h, d, b, model_revealed(), 3'(m_misses), w, !w && (m_misses == MAXM)};
  endfunction

  task automatic model_new(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c,
                           input logic [5:0] d);
    m_word[0] = a; m_word[1] = b; m_word[2] = c; m_word[3] = d;
    m_guessed.delete();
    m_misses = 0;
  endtask

  task automatic model_guess(input logic [5:0] g);
    bit b, d, h;
    b = (g < 6'h0A) || (g > 6'h23);
    d = !b && was_guessed(g);
    h = 1'b0;
    if (!b && !d) begin
      foreach (m_word[i]) if (m_word[i] == g) h = 1'b1;
      m_guessed.push_back(g);
      if (!h && m_misses < MAXM) m_misses++;
    end
    exp_q.push_back(model_status(h, d, b));
  endtask

  function automatic logic [W-1:0] dut_status();
    return {hit, dup, bad, revealed, misses, won, lost};
  endfunction

  always @(negedge clock) begin
    if (!reset && result_valid) begin
      if (exp_q.size() == 0) check_eq("unexpected_result", 32'(exp_q.size()), 1);
      else check_eq("result", 32'(dut_status()), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks (entered and left at a falling edge) ----------------
  task automatic scramble_letters();
    letter1 = 6'($urandom_range(10, 35));
    letter2 = 6'($urandom_range(10, 35));
    letter3 = 6'($urandom_range(10, 35));
    letter4 = 6'($urandom_range(10, 35));
  endtask

  task automatic start_game(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c,
                            input logic [5:0] d);
    new_game = 1'b1;
    letter1 = a; letter2 = b; letter3 = c; letter4 = d;
    @(posedge clock);
    model_new(a, b, c, d);
    @(negedge clock);
    new_game = 1'b0;
    scramble_letters();
    check_eq("ng_ready", 32'(guess_ready), 1);
    check_eq("ng_status", 32'(dut_status()), 32'(model_status(1'b0, 1'b0, 1'b0)));
    check_eq("ng_shown", 32'({shown1, shown2, shown3, shown4}), 32'(model_shown()));
  endtask

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    while (guess_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    ok = (guess_ready === 1'b1);
    check_eq("ready_wait", 32'(guess_ready), 1);
  endtask

  // guess_valid stays high through the CHECK cycle to show it is ignored there.
  task automatic send_guess(input logic [5:0] g);
    bit ok;
    wait_ready(ok);
    if (ok) begin
      guess_valid = 1'b1;
      guess       = g;
      @(posedge clock);
      model_guess(g);
      @(negedge clock);
      check_eq("ready_in_check", 32'(guess_ready), 0);
      check_eq("rv_early", 32'(result_valid), 0);
      @(negedge clock);
      guess_valid = 1'b0;
      check_eq("rv_pulse", 32'(result_valid), 1);
      check_eq("shown", 32'({shown1, shown2, shown3, shown4}), 32'(model_shown()));
      check_eq("ready_after", 32'(guess_ready), 32'(!model_over()));
    end
  endtask

  task automatic probe_closed();
    guess_valid = 1'b1;
    guess       = 6'h0A;
    repeat (3) begin
      @(negedge clock);
      check_eq("closed_ready", 32'(guess_ready), 0);
    end
    guess_valid = 1'b0;
    check_eq("over_level", 32'({won, lost}),
             32'({model_won(), !model_won() && (m_misses == MAXM)}));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] g;
    bit         ok;
    int         n;

    @(negedge clock);
    check_eq("rst_status", 32'(dut_status()), 0);
    check_eq("rst_rv", 32'(result_valid), 0);
    check_eq("rst_ready", 32'(guess_ready), 0);
    check_eq("rst_shown", 32'({shown1, shown2, shown3, shown4}), 32'(24'hFFFFFF));
    reset = 1'b0;
    @(negedge clock);
    check_eq("idle_ready", 32'(guess_ready), 0);

    // HEAD: hit then duplicate
    start_game(6'h11, 6'h0E, 6'h0A, 6'h0D);
    send_guess(6'h0E);
    check_eq("head_rev", 32'(revealed), 32'(4'b0010));
    check_eq("head_shown2", 32'(shown2), 32'(6'h0E));
    send_guess(6'h0E);
    check_eq("head_dup_rev", 32'(revealed), 32'(4'b0010));
    check_eq("head_dup_miss", 32'(misses), 0);

    // AABB: repeated letters revealed together, then win
    start_game(6'h0A, 6'h0A, 6'h0B, 6'h0B);
    send_guess(6'h0A);
    check_eq("aabb_rev", 32'(revealed), 32'(4'b0011));
    send_guess(6'h0B);
    check_eq("aabb_won", 32'(won), 1);
    probe_closed();

    // STAY: bad code then hit, then reset in the middle of CHECK
    start_game(6'h1C, 6'h1D, 6'h0A, 6'h22);
    send_guess(6'h05);
    check_eq("bad_miss", 32'(misses), 0);
    send_guess(6'h0A);
    check_eq("stay_rev", 32'(revealed), 32'(4'b0100));
    wait_ready(ok);
    guess_valid = 1'b1;
    guess       = 6'h1C;
    @(posedge clock);
    @(negedge clock);
    guess_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_status", 32'(dut_status()), 0);
    check_eq("async_rst_shown", 32'({shown1, shown2, shown3, shown4}), 32'(24'hFFFFFF));
    check_eq("async_rst_ready", 32'(guess_ready), 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_eq("post_rst_rv", 32'(result_valid), 0);

    // STAY: loss after six misses
    start_game(6'h1C, 6'h1D, 6'h0A, 6'h22);
    for (int i = 0; i < 6; i++) send_guess(6'(6'h0B + i));
    check_eq("stay_misses", 32'(misses), 6);
    check_eq("stay_lost", 32'(lost), 1);
    probe_closed();

    // Restart priority: new_game during CHECK, then new_game with a same-cycle guess
    start_game(6'h11, 6'h0E, 6'h0A, 6'h0D);
    wait_ready(ok);
    guess_valid = 1'b1;
    guess       = 6'h11;
    @(posedge clock);
    @(negedge clock);
    guess_valid = 1'b0;
    new_game    = 1'b1;
    letter1 = 6'h13; letter2 = 6'h1E; letter3 = 6'h16; letter4 = 6'h19;
    @(posedge clock);
    model_new(6'h13, 6'h1E, 6'h16, 6'h19);
    @(negedge clock);
    new_game = 1'b0;
    scramble_letters();
    check_eq("abandon_rv", 32'(result_valid), 0);
    check_eq("abandon_status", 32'(dut_status()), 32'(model_status(1'b0, 1'b0, 1'b0)));
    @(negedge clock);
    check_eq("abandon_rv2", 32'(result_valid), 0);
    new_game    = 1'b1;
    guess_valid = 1'b1;
    guess       = 6'h13;
    letter1 = 6'h0C; letter2 = 6'h18; letter3 = 6'h0D; letter4 = 6'h0E;
    @(posedge clock);
    model_new(6'h0C, 6'h18, 6'h0D, 6'h0E);
    @(negedge clock);
    new_game    = 1'b0;
    guess_valid = 1'b0;
    scramble_letters();
    check_eq("drop_ready", 32'(guess_ready), 1);
    @(negedge clock);
    check_eq("drop_rv", 32'(result_valid), 0);
    check_eq("drop_status", 32'(dut_status()), 32'(model_status(1'b0, 1'b0, 1'b0)));
    send_guess(6'h18);
    send_guess(6'h13);

    // Random games
    for (int game = 0; game < 10; game++) begin
      start_game(6'($urandom_range(10, 35)), 6'($urandom_range(10, 35)),
                 6'($urandom_range(10, 35)), 6'($urandom_range(10, 35)));
      n = 0;
      while (!model_over() && n < 30) begin
        case ($urandom_range(0, 9))
          0:       g = 6'($urandom_range(0, 63));
          1, 2, 3: g = m_word[$urandom_range(0, 3)];
          default: g = 6'($urandom_range(10, 35));
        endcase
        send_guess(g);
        n++;
      end
      if (model_over()) probe_closed();
    end

    repeat (3) @(negedge clock);
    check_eq("queue_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
